// File: rtl/sccb_target.sv
`default_nettype none
// ============================================================================
// Module   : sccb_target
// Brief    : SCCB responder with a 256x8 register file (camera emulation).
//            Define SCCB_TARGET_READ_EN to build 2-phase read (TX) support.
// Revision : 1.0
// ============================================================================
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter int         SYNC_N = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] mon_addr,
  output logic [7:0] mon_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DEV    = 3'd1;
  localparam logic [2:0] ST_ACK    = 3'd2;
  localparam logic [2:0] ST_SUB    = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;
`ifdef SCCB_TARGET_READ_EN
  localparam logic [2:0] ST_TX     = 3'd6;
`endif

  localparam logic [1:0] PH_DEV_WR = 2'd0;
  localparam logic [1:0] PH_SUB    = 2'd1;
  localparam logic [1:0] PH_DATA   = 2'd2;
`ifdef SCCB_TARGET_READ_EN
  localparam logic [1:0] PH_DEV_RD = 2'd3;
`endif

  logic [SYNC_N-1:0] r_sioc_sync;
  logic [SYNC_N-1:0] r_siod_sync;
  logic              r_sioc_d;
  logic              r_siod_d;
  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [1:0]        r_phase;
  logic [3:0]        r_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_ptr;
  logic              r_ack_drv;
  logic              r_wr_pend;
  logic              r_siod_oe;
  logic              w_oe_nxt;
  logic [7:0]        r_regfile [256];

  logic       w_scl;
  logic       w_sda;
  logic       w_rise;
  logic       w_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_last;
  logic       w_dev_ok;
  logic [7:0] w_byte;

  // Idle bus is high on both lines, so the synchronisers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sioc_sync <= '1;
      r_siod_sync <= '1;
      r_sioc_d    <= 1'b1;
      r_siod_d    <= 1'b1;
    end else begin
      r_sioc_sync <= {r_sioc_sync[SYNC_N-2:0], sioc};
      r_siod_sync <= {r_siod_sync[SYNC_N-2:0], siod_in};
      r_sioc_d    <= r_sioc_sync[SYNC_N-1];
      r_siod_d    <= r_siod_sync[SYNC_N-1];
    end
  end

  assign w_scl   = r_sioc_sync[SYNC_N-1];
  assign w_sda   = r_siod_sync[SYNC_N-1];
  assign w_rise  = w_scl & ~r_sioc_d;
  assign w_fall  = ~w_scl & r_sioc_d;
  assign w_start = w_scl & r_sioc_d & r_siod_d & ~w_sda;
  assign w_stop  = w_scl & r_sioc_d & ~r_siod_d & w_sda;
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_last  = w_rise & (r_cnt == 4'd7);

`ifdef SCCB_TARGET_READ_EN
  assign w_dev_ok = (w_byte[7:1] == DEV_ID);
`else
  assign w_dev_ok = (w_byte[7:1] == DEV_ID) & ~w_byte[0];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_IGNORE: w_state_nxt = r_state;
      ST_DEV: begin
        if (w_last) w_state_nxt = w_dev_ok ? ST_ACK : ST_IGNORE;
      end
      ST_SUB, ST_DATA: begin
        if (w_last) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_fall && r_ack_drv) begin
          case (r_phase)
            PH_DEV_WR:       w_state_nxt = ST_SUB;
            PH_SUB, PH_DATA: w_state_nxt = ST_DATA;
`ifdef SCCB_TARGET_READ_EN
            PH_DEV_RD:       w_state_nxt = ST_TX;
`endif
            default:         w_state_nxt = ST_IGNORE;
          endcase
        end
      end
`ifdef SCCB_TARGET_READ_EN
      ST_TX: begin
        if (w_rise && r_cnt[3] && w_sda) w_state_nxt = ST_IGNORE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_stop)       w_state_nxt = ST_IDLE;
    else if (w_start) w_state_nxt = ST_DEV;
  end

`ifdef SCCB_TARGET_READ_EN
  logic [2:0] w_tx_idx;
  assign w_tx_idx = 3'd7 - r_cnt[2:0];
`endif

  always_comb begin
    busy     = (r_state != ST_IDLE);
    w_oe_nxt = 1'b0;
    if (!(w_start || w_stop)) begin
      case (r_state)
        ST_ACK: begin
          w_oe_nxt = r_siod_oe;
          if (w_fall) begin
            if (!r_ack_drv)                w_oe_nxt = 1'b1;
`ifdef SCCB_TARGET_READ_EN
            // The first read bit replaces the ACK on the same falling edge.
            else if (r_phase == PH_DEV_RD) w_oe_nxt = ~r_regfile[r_ptr][7];
`endif
            else                           w_oe_nxt = 1'b0;
          end
        end
`ifdef SCCB_TARGET_READ_EN
        ST_TX: begin
          w_oe_nxt = r_siod_oe;
          if (w_fall) w_oe_nxt = r_cnt[3] ? 1'b0 : ~r_regfile[r_ptr][w_tx_idx];
        end
`endif
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_siod_oe <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      r_wr_pend <= 1'b0;
      r_ptr     <= 8'h00;
      r_shift   <= 8'h00;
      r_cnt     <= 4'd0;
      r_phase   <= PH_DEV_WR;
      r_ack_drv <= 1'b0;
    end else begin
      r_siod_oe <= w_oe_nxt;
      wr_stb    <= 1'b0;
      r_wr_pend <= 1'b0;
      // The write commits independently of bus conditions, so a START in this clk cannot drop it.
      if (r_wr_pend) begin
        wr_stb  <= 1'b1;
        wr_addr <= r_ptr;
        wr_data <= r_shift;
        r_ptr   <= r_ptr + 8'd1;
      end
      if (w_start || w_stop) begin
        r_cnt     <= 4'd0;
        r_ack_drv <= 1'b0;
      end else begin
        case (r_state)
          ST_DEV, ST_SUB, ST_DATA: begin
            if (w_rise) begin
              r_shift <= w_byte;
              r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
              if (w_last) begin
                if (r_state == ST_DEV) begin
`ifdef SCCB_TARGET_READ_EN
                  r_phase <= w_byte[0] ? PH_DEV_RD : PH_DEV_WR;
`else
                  r_phase <= PH_DEV_WR;
`endif
                end else if (r_state == ST_SUB) begin
                  r_ptr   <= w_byte;
                  r_phase <= PH_SUB;
                end else begin
                  r_wr_pend <= 1'b1;
                  r_phase   <= PH_DATA;
                end
              end
            end
          end
          ST_ACK: begin
            if (w_fall) r_ack_drv <= ~r_ack_drv;
          end
`ifdef SCCB_TARGET_READ_EN
          ST_TX: begin
            if (w_rise) begin
              if (r_cnt[3]) begin
                r_cnt <= 4'd0;
                if (!w_sda) r_ptr <= r_ptr + 8'd1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
`endif
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) r_regfile[i] <= 8'h00;
    end else if (r_wr_pend) begin
      r_regfile[r_ptr] <= r_shift;
    end
  end

  assign siod_oe  = r_siod_oe;
  assign mon_data = r_regfile[mon_addr];

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_target
// Brief    : Randomised SCCB master driving sccb_target against a register-map model.
// Revision : 1.0
// ============================================================================
module tb_sccb_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       sioc = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] mon_addr = 8'h00;
  logic       siod_line;
  logic       siod_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] mon_data;

  assign siod_line = ~(m_low | siod_oe);

  sccb_target dut (
    .clk      (clk),
    .rstn     (rstn),
    .sioc     (sioc),
    .siod_in  (siod_line),
    .siod_oe  (siod_oe),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .mon_addr (mon_addr),
    .mon_data (mon_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int oe_viol = 0;

  logic [7:0]  mem [256];
  logic [7:0]  mptr = 8'h00;
  logic [7:0]  tx_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] act_q [$];

  always @(negedge clk) if (wr_stb) act_q.push_back({wr_addr, wr_data});

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_low = 1'b0; tick(Q);
    sioc  = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    sioc  = 1'b0; tick(Q);
  endtask

  task automatic m_stop;
    m_low = 1'b1; tick(Q);
    sioc  = 1'b1; tick(Q);
    m_low = 1'b0; tick(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_low = ~b[7-i]; tick(Q);
      sioc  = 1'b1;    tick(Q);
      if (siod_oe) oe_viol++;
      tick(Q);
      sioc  = 1'b0;    tick(Q);
    end
  endtask

  task automatic get_ack(output logic nack);
    m_low = 1'b0; tick(Q);
    sioc  = 1'b1; tick(Q);
    nack  = siod_line; tick(Q);
    sioc  = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      sioc = 1'b1; tick(Q);
      v[7-i] = siod_line; tick(Q);
      sioc = 1'b0; tick(Q);
    end
    m_low = ~nack; tick(Q);
    sioc  = 1'b1;  tick(2*Q);
    sioc  = 1'b0;  tick(Q);
    m_low = 1'b0;
    b = v;
  endtask

  task automatic compare_writes;
    check_val("wr_count", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      check_val("wr_event", act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  // Write transaction: dev byte, then tx_q (sub-address first, data after).
  task automatic do_write(input logic [7:0] dev);
    logic nack;
    logic acked;
    acked = (dev[7:1] == 7'h21) && (dev[0] == 1'b0);
    m_start;
    check_val("busy_start", busy, 1);
    send_bits(dev, 8);
    get_ack(nack);
    check_val("dev_ack", nack, !acked);
    foreach (tx_q[i]) begin
      send_bits(tx_q[i], 8);
      get_ack(nack);
      check_val("byte_ack", nack, !acked);
      if (acked) begin
        if (i == 0) mptr = tx_q[i];
        else begin
          mem[mptr] = tx_q[i];
          exp_q.push_back({mptr, tx_q[i]});
          mptr = mptr + 8'd1;
        end
      end
    end
    check_val("busy_pre_stop", busy, 1);
    m_stop;
    check_val("busy_stop", busy, 0);
    compare_writes();
  endtask

  task automatic do_read(input int n);
    logic nack;
    logic [7:0] b;
    m_start;
    send_bits(8'h43, 8);
    get_ack(nack);
`ifdef SCCB_TARGET_READ_EN
    check_val("rd_dev_ack", nack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i == n-1);
      check_val("rd_byte", b, mem[mptr]);
      if (i != n-1) mptr = mptr + 8'd1;
    end
`else
    check_val("rd_dev_nack", nack, 1);
    b = 8'h00;
    if (n < 0) $display("read length %0d %0h", n, b);
`endif
    check_val("busy_ignore", busy, 1);
    m_stop;
    check_val("busy_rd_stop", busy, 0);
    compare_writes();
  endtask

  task automatic check_mem(input logic [7:0] a);
    mon_addr = a;
    tick(1);
    check_val("mon_data", mon_data, mem[a]);
  endtask

  initial begin
    logic nack;
    logic [7:0] dev;
    int nb;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    // Reset with idle bus
    #1 rstn = 1'b0;
    tick(4);
    mon_addr = 8'h12;
    tick(1);
    check_val("rst_oe", siod_oe, 0);
    check_val("rst_stb", wr_stb, 0);
    check_val("rst_addr", wr_addr, 0);
    check_val("rst_data", wr_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_mon", mon_data, 0);
    rstn = 1'b1;
    tick(4);

    // Single write 42/12/80
    tx_q = '{8'h12, 8'h80};
    do_write(8'h42);
    check_mem(8'h12);

    // Burst with address wrap
    tx_q = '{8'hFE, 8'hAA, 8'hBB, 8'hCC};
    do_write(8'h42);
    check_mem(8'hFE);
    check_mem(8'hFF);
    check_mem(8'h00);

    // Foreign device ID
    oe_viol = 0;
    tx_q = '{8'h11, 8'h22};
    do_write(8'h60);
    check_val("ignore_oe", oe_viol, 0);

    // Repeated START in the middle of the sub-address
    m_start;
    send_bits(8'h42, 8);
    get_ack(nack);
    check_val("rs_dev_ack", nack, 0);
    send_bits(8'h33, 4);
    tx_q = '{8'h05, 8'h5A};
    do_write(8'h42);
    check_mem(8'h05);

    // Read back from 12
    tx_q = '{8'h12};
    do_write(8'h42);
    do_read(3);

    // Randomised traffic
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        tx_q = '{8'($urandom)};
        do_write(8'h42);
        do_read(int'($urandom_range(1, 3)));
      end else begin
        dev = 8'h42;
        if ($urandom_range(0, 3) == 0) begin
          dev = 8'($urandom) & 8'hFE;
          if (dev[7:1] == 7'h21) dev = dev ^ 8'h80;
        end
        nb = int'($urandom_range(1, 3));
        tx_q = '{8'($urandom)};
        for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom));
        do_write(dev);
      end
    end

    // Reset while the target drives ACK
    m_start;
    send_bits(8'h42, 8);
    m_low = 1'b0;
    tick(Q);
    check_val("ack_drive", siod_oe, 1);
    rstn = 1'b0;
    #1;
    check_val("midrst_oe", siod_oe, 0);
    check_val("midrst_busy", busy, 0);
    tick(2);
    sioc = 1'b1;
    tick(4);
    rstn = 1'b1;
    tick(4);
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mptr = 8'h00;
    act_q.delete();
    tx_q = '{8'h30, 8'h7E, 8'h81};
    do_write(8'h42);
    check_val("oe_quiet", oe_viol, 0);

    for (int a = 0; a < 256; a++) check_mem(8'(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
